// File: rtl/frodo_row_acc_if.sv
// Bundle of job control, upstream partial stream and downstream element stream
// for frodo_row_acc. The master side drives the i_* signals.
interface frodo_row_acc_if #(
  parameter int WIDTH = 16
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; the sender holds valid and data stable until that edge, ready never
  // depends combinationally on valid.
  logic [2:0]       i_sec_lev;
  logic             i_start;
  logic [15:0]      i_num_elem;
  logic             i_valid;
  logic [WIDTH-1:0] i_partial;
  logic [WIDTH-1:0] i_err;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_elem;
  logic             i_ready;
  logic             o_busy;
  logic             o_done;
  logic [1:0]       o_state;

  modport master (
    output i_sec_lev, i_start, i_num_elem, i_valid, i_partial, i_err, i_ready,
    input  o_ready, o_valid, o_elem, o_busy, o_done, o_state
  );

  modport slave (
    input  i_sec_lev, i_start, i_num_elem, i_valid, i_partial, i_err, i_ready,
    output o_ready, o_valid, o_elem, o_busy, o_done, o_state
  );
endinterface

// File: rtl/frodo_row_acc.sv
// Collects n/T tree-adder partials plus an error term into one FrodoKEM matrix
// element, reduces it mod q and streams it out; counts elements per job.
module frodo_row_acc #(
  parameter int T     = 16,
  parameter int WIDTH = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  frodo_row_acc_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BW = 11;
  localparam logic [BW-1:0]    BEATS_640  = BW'(640 / T);
  localparam logic [BW-1:0]    BEATS_976  = BW'(976 / T);
  localparam logic [BW-1:0]    BEATS_1344 = BW'(1344 / T);
  localparam logic [WIDTH-1:0] MASK_Q15   = WIDTH'((32'd1 << 15) - 32'd1);
  localparam logic [WIDTH-1:0] MASK_Q16   = WIDTH'((32'd1 << 16) - 32'd1);

  state_t           state_q, state_d;
  logic [BW-1:0]    beats_q, beat_cnt_q;
  logic [WIDTH-1:0] mask_q, acc_q, elem_q;
  logic [15:0]      num_elem_q, elem_cnt_q;

  logic [BW-1:0]    beats_sel;
  logic [WIDTH-1:0] mask_sel;
  logic [WIDTH-1:0] acc_next;
  logic             last_beat, last_elem;

  // Unknown security levels fall back to Frodo-640.
  always_comb begin
    beats_sel = BEATS_640;
    mask_sel  = MASK_Q15;
    case (bus.i_sec_lev)
      3'd3: begin beats_sel = BEATS_976;  mask_sel = MASK_Q16; end
      3'd5: begin beats_sel = BEATS_1344; mask_sel = MASK_Q16; end
      default: begin beats_sel = BEATS_640; mask_sel = MASK_Q15; end
    endcase
  end

  // The accumulator stays full width; reduction is applied only when the
  // element is registered for output, since it commutes with addition.
  assign acc_next  = ((beat_cnt_q == '0) ? bus.i_err : acc_q) + bus.i_partial;
  assign last_beat = (beat_cnt_q == (beats_q - BW'(1)));
  assign last_elem = ((elem_cnt_q + 16'd1) == num_elem_q);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.i_start) state_d = (bus.i_num_elem == 16'd0) ? DONE : ACC;
      ACC:  if (bus.i_valid && last_beat) state_d = OUT;
      OUT:  if (bus.i_ready) state_d = last_elem ? DONE : ACC;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      beats_q    <= '0;
      beat_cnt_q <= '0;
      mask_q     <= '0;
      acc_q      <= '0;
      elem_q     <= '0;
      num_elem_q <= '0;
      elem_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            beats_q    <= beats_sel;
            mask_q     <= mask_sel;
            num_elem_q <= bus.i_num_elem;
            beat_cnt_q <= '0;
            elem_cnt_q <= '0;
          end
        end
        ACC: begin
          if (bus.i_valid) begin
            acc_q <= acc_next;
            if (last_beat) begin
              elem_q     <= acc_next & mask_q;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + BW'(1);
            end
          end
        end
        OUT: begin
          if (bus.i_ready) elem_cnt_q <= elem_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready = (state_q == ACC);
  assign bus.o_valid = (state_q == OUT);
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_done  = (state_q == DONE);
  assign bus.o_elem  = elem_q;
  assign bus.o_state = state_q;

endmodule

// File: tb/tb_frodo_row_acc.sv
// Directed bench for frodo_row_acc: jobs at each security level, backpressure,
// reset mid-row and zero-length jobs, with a queue of expected elements.
module tb_frodo_row_acc;
  localparam int WIDTH = 16;
  localparam int T     = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frodo_row_acc_if #(.WIDTH(WIDTH)) bus ();

  frodo_row_acc #(.T(T), .WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [WIDTH-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int out_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling edge; inputs change just after rising edges.
  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    if (rst_n && bus.o_done) done_cnt++;
    if (rst_n && bus.o_valid && bus.i_ready) begin
      out_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("elem", 32'(bus.o_elem), 32'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] e);
    logic rdy;
    int guard;
    guard = 0;
    bus.i_valid   = 1'b1;
    bus.i_partial = p;
    bus.i_err     = e;
    do begin
      rdy = bus.o_ready;
      tick();
      guard++;
    end while (!rdy && guard < 200);
    bus.i_valid = 1'b0;
    if (!rdy) check("beat_accept_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic feed(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] p,
                      input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && i > 0) tick();
      send_beat(p, e);
    end
  endtask

  task automatic start_job(input logic [2:0] sec, input logic [15:0] num);
    bus.i_sec_lev  = sec;
    bus.i_num_elem = num;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start    = 1'b0;
  endtask

  // One-element job with a constant partial; checks beat count, output timing and done.
  task automatic job1(input string tag, input logic [2:0] sec, input logic [WIDTH-1:0] e,
                      input logic [WIDTH-1:0] p, input int nbeats, input logic [WIDTH-1:0] exp);
    int d0;
    start_job(sec, 16'd1);
    check({tag, "_ready_after_start"}, 32'(bus.o_ready), 32'd1);
    check({tag, "_busy_after_start"}, 32'(bus.o_busy), 32'd1);
    exp_q.push_back(exp);
    feed(e, p, nbeats - 1, 1'b0);
    check({tag, "_no_valid_early"}, 32'(bus.o_valid), 32'd0);
    feed(e, p, 1, 1'b0);
    check({tag, "_valid_after_last"}, 32'(bus.o_valid), 32'd1);
    d0 = done_cnt;
    tick();
    check({tag, "_done_pulse"}, 32'(bus.o_done), 32'd1);
    tick();
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] r;
    int d0;
    int o0;

    bus.i_sec_lev  = 3'd1;
    bus.i_start    = 1'b0;
    bus.i_num_elem = 16'd0;
    bus.i_valid    = 1'b0;
    bus.i_partial  = '0;
    bus.i_err      = '0;
    bus.i_ready    = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_elem",  32'(bus.o_elem),  32'd0);
    check("rst_busy",  32'(bus.o_busy),  32'd0);
    check("rst_done",  32'(bus.o_done),  32'd0);
    check("rst_state", 32'(bus.o_state), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic 640 row and wrap/mask
    job1("t1_basic", 3'd1, 16'd5, 16'd1, 40, 16'h002D);
    job1("t2_wrap", 3'd1, 16'd0, 16'hFFFF, 40, 16'h7FD8);

    // 976 level: the 62nd valid must not be consumed
    start_job(3'd3, 16'd1);
    exp_q.push_back(16'hD100);
    bus.i_ready = 1'b0;
    feed(16'h0100, 16'h1000, 60, 1'b0);
    check("t3_ready_before_61", 32'(bus.o_ready), 32'd1);
    feed(16'h0100, 16'h1000, 1, 1'b0);
    bus.i_valid = 1'b1;
    check("t3_no_62nd_ready", 32'(bus.o_ready), 32'd0);
    check("t3_valid", 32'(bus.o_valid), 32'd1);
    tick();
    check("t3_valid_held", 32'(bus.o_valid), 32'd1);
    check("t3_still_not_ready", 32'(bus.o_ready), 32'd0);
    bus.i_ready = 1'b1;
    tick();
    check("t3_done", 32'(bus.o_done), 32'd1);
    bus.i_valid = 1'b0;
    tick();

    // Multi-element 1344 job with gaps; sec_lev change mid-job must be ignored
    o0 = out_cnt;
    start_job(3'd5, 16'd3);
    bus.i_sec_lev = 3'd1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(WIDTH'(84 + k));
      feed(WIDTH'(k), 16'd1, 84, 1'b1);
      check("t4_valid_after_last", 32'(bus.o_valid), 32'd1);
    end
    d0 = done_cnt;
    tick();
    check("t4_done_after_third", 32'(bus.o_done), 32'd1);
    tick();
    check("t4_done_count", 32'(done_cnt - d0), 32'd1);
    check("t4_out_count", 32'(out_cnt - o0), 32'd3);

    // Backpressure with an ignored start
    d0 = done_cnt;
    start_job(3'd1, 16'd1);
    bus.i_ready = 1'b0;
    exp_q.push_back(16'd87);
    feed(16'd7, 16'd2, 40, 1'b0);
    for (int c = 0; c < 10; c++) begin
      check("t5_valid_held", 32'(bus.o_valid), 32'd1);
      check("t5_ready_low", 32'(bus.o_ready), 32'd0);
      check("t5_elem_stable", 32'(bus.o_elem), 32'd87);
      if (c == 3) begin
        bus.i_start    = 1'b1;
        bus.i_num_elem = 16'd5;
        bus.i_sec_lev  = 3'd3;
      end
      if (c == 4) bus.i_start = 1'b0;
      tick();
    end
    bus.i_ready = 1'b1;
    tick();
    check("t5_done", 32'(bus.o_done), 32'd1);
    tick();
    check("t5_idle", 32'(bus.o_busy), 32'd0);
    check("t5_done_count", 32'(done_cnt - d0), 32'd1);

    // Random data at 1344
    r = WIDTH'($urandom_range(0, 16'hFFFF));
    sum = r;
    start_job(3'd5, 16'd1);
    bus.i_err = r;
    for (int i = 0; i < 84; i++) begin
      logic [WIDTH-1:0] p;
      p = WIDTH'($urandom_range(0, 16'hFFFF));
      sum = sum + p;
      if (i == 83) exp_q.push_back(sum);
      send_beat(p, r);
      if ($urandom_range(0, 1) == 1) tick();
    end
    check("t6_valid", 32'(bus.o_valid), 32'd1);
    tick();
    check("t6_done", 32'(bus.o_done), 32'd1);
    tick();

    // Unknown security level behaves as 640
    job1("t7_sec2", 3'd2, 16'd0, 16'h0400, 40, 16'h2000);

    // Reset mid-row, then a zero-length job, then a clean job
    start_job(3'd1, 16'd1);
    feed(16'd9, 16'd1, 20, 1'b0);
    rst_n = 1'b0;
    tick();
    check("t8_rst_ready", 32'(bus.o_ready), 32'd0);
    check("t8_rst_valid", 32'(bus.o_valid), 32'd0);
    check("t8_rst_elem",  32'(bus.o_elem),  32'd0);
    check("t8_rst_busy",  32'(bus.o_busy),  32'd0);
    check("t8_rst_done",  32'(bus.o_done),  32'd0);
    d0 = done_cnt;
    rst_n = 1'b1;
    tick();
    tick();
    check("t8_no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    o0 = out_cnt;
    start_job(3'd1, 16'd0);
    check("t8_zero_done", 32'(bus.o_done), 32'd1);
    check("t8_zero_no_valid", 32'(bus.o_valid), 32'd0);
    tick();
    check("t8_zero_done_clear", 32'(bus.o_done), 32'd0);
    check("t8_zero_idle", 32'(bus.o_busy), 32'd0);
    check("t8_zero_no_output", 32'(out_cnt - o0), 32'd0);
    job1("t8_after", 3'd1, 16'd3, 16'd1, 40, 16'd43);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
